// File: rtl/tff_count_sequencer.sv
// Programmable up/down counter built from a bank of toggle cells. The controller
// computes the per-bit toggle vector each cycle and sequences load/run/stop/terminal.
module tff_count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             dir,
    input  logic             cont,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] T_out,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] limit_r;
    logic             dir_r;
    logic             cont_r;

    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic             terminal;
    logic             running;
    logic             accept_start;

    assign running      = (state == RUN);
    assign busy         = running;
    assign terminal     = dir_r ? (Q == limit_r) : (Q == '0);
    assign tc           = running && terminal;
    assign accept_start = (state == IDLE) && start && !stop;

    // Ripple of "all lower bits set" (up) or "all lower bits clear" (down).
    always_comb begin
        logic up_c;
        logic dn_c;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        up_t = '0;
        dn_t = '0;
        up_c = 1'b1;
        dn_c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i] = up_c;
            dn_t[i] = dn_c;
            // NOTE: blocking assignments here are intentional: the carry is a
            // combinational temporary read back within the same pass.
            up_c    = up_c & Q[i];
            dn_c    = dn_c & ~Q[i];
        end
    end

    // Toggle vector, highest priority first; stop in RUN freezes the bank.
    always_comb begin
        T_out = '0;
        if (running && stop) begin
            T_out = '0;
        end else if (load) begin
            T_out = Q ^ load_val;
        end else if (running && terminal) begin
            if (cont_r)
                T_out = Q ^ (dir_r ? '0 : limit_r);
            else
                T_out = '0;
        end else if (running) begin
            T_out = dir_r ? up_t : dn_t;
        end
    end

    // Q only ever changes through its toggle vector.
    always_ff @(posedge Clk) begin
        if (rst) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state   <= IDLE;
            Q       <= '0;
            limit_r <= '0;
            dir_r   <= 1'b0;
            cont_r  <= 1'b0;
            done    <= 1'b0;
        end else begin
            Q    <= Q ^ T_out;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_start) begin
                        limit_r <= limit;
                        dir_r   <= dir;
                        cont_r  <= cont;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (!load && terminal && !cont_r) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Directed bench for tff_count_sequencer: expected post-edge Q/busy/done values are
// queued when each step is driven and compared after the clock edge.
module tb_tff_count_sequencer;

    logic       Clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] limit;
    logic       dir;
    logic       cont;
    logic [3:0] Q;
    logic [3:0] T_out;
    logic       busy;
    logic       tc;
    logic       done;

    typedef struct {
        logic [3:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t  sb[$];
    int    checks   = 0;
    int    failures = 0;
    string step     = "init";

    tff_count_sequencer #(.WIDTH(4)) dut (
        .Clk     (Clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .load    (load),
        .load_val(load_val),
        .limit   (limit),
        .dir     (dir),
        .cont    (cont),
        .Q       (Q),
        .T_out   (T_out),
        .busy    (busy),
        .tc      (tc),
        .done    (done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp_v);
        end
    endtask

    task automatic expect_next(input logic [3:0] q, input logic b, input logic d);
        exp_t e;
        e.q    = q;
        e.busy = b;
        e.done = d;
        sb.push_back(e);
    endtask

    // Advance one edge and compare against the oldest queued expectation.
    task automatic tick();
        exp_t e;
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s/scoreboard observed=empty expected=entry", step);
        end else begin
            e = sb.pop_front();
            check("Q",    {4'b0, Q},    {4'b0, e.q});
            check("busy", {7'b0, busy}, {7'b0, e.busy});
            check("done", {7'b0, done}, {7'b0, e.done});
        end
    endtask

    task automatic idle_inputs();
        start    = 1'b0;
        stop     = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; stop = 1'b0; load = 1'b1; load_val = 4'd9;
        limit = 4'd0; dir = 1'b0; cont = 1'b0;

        step = "reset";
        expect_next(4'd0, 1'b0, 1'b0); tick();
        expect_next(4'd0, 1'b0, 1'b0); tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        check("T_out_idle", {4'b0, T_out}, 8'h00);
        check("tc_idle",    {7'b0, tc},    8'h00);

        step = "oneshot_up";
        start = 1'b1; limit = 4'd5; dir = 1'b1; cont = 1'b0;
        expect_next(4'd0, 1'b1, 1'b0); tick();
        start = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            if (v == 2) begin
                start = 1'b1; limit = 4'd1; dir = 1'b0;
            end else begin
                start = 1'b0;
            end
            expect_next(v[3:0], 1'b1, 1'b0); tick();
        end
        start = 1'b0;
        check("tc_at_limit", {7'b0, tc},    8'h01);
        check("T_out_term",  {4'b0, T_out}, 8'h00);
        expect_next(4'd5, 1'b0, 1'b1); tick();
        expect_next(4'd5, 1'b0, 1'b0); tick();

        step = "tvec_up";
        load = 1'b1; load_val = 4'd7; start = 1'b1; dir = 1'b1; limit = 4'd15; cont = 1'b0;
        expect_next(4'd7, 1'b1, 1'b0); tick();
        idle_inputs();
        #1;
        check("T_out_0111_up", {4'b0, T_out}, 8'h0f);
        expect_next(4'd8, 1'b1, 1'b0); tick();
        stop = 1'b1;
        #1;
        check("T_out_stop", {4'b0, T_out}, 8'h00);
        expect_next(4'd8, 1'b0, 1'b0); tick();

        step = "tvec_down";
        idle_inputs();
        start = 1'b1; dir = 1'b0; limit = 4'd3; cont = 1'b0;
        expect_next(4'd8, 1'b1, 1'b0); tick();
        idle_inputs();
        #1;
        check("T_out_1000_down", {4'b0, T_out}, 8'h0f);
        expect_next(4'd7, 1'b1, 1'b0); tick();
        stop = 1'b1;
        expect_next(4'd7, 1'b0, 1'b0); tick();

        step = "cont_down";
        idle_inputs();
        load = 1'b1; load_val = 4'd3; start = 1'b1; dir = 1'b0; limit = 4'd3; cont = 1'b1;
        expect_next(4'd3, 1'b1, 1'b0); tick();
        idle_inputs();
        expect_next(4'd2, 1'b1, 1'b0); tick();
        expect_next(4'd1, 1'b1, 1'b0); tick();
        expect_next(4'd0, 1'b1, 1'b0); tick();
        check("tc_at_zero",     {7'b0, tc},    8'h01);
        check("T_out_reload",   {4'b0, T_out}, 8'h03);
        expect_next(4'd3, 1'b1, 1'b0); tick();
        expect_next(4'd2, 1'b1, 1'b0); tick();
        stop = 1'b1;
        expect_next(4'd2, 1'b0, 1'b0); tick();

        step = "stop_priority";
        idle_inputs();
        load = 1'b1; load_val = 4'd4; start = 1'b1; dir = 1'b1; limit = 4'd15; cont = 1'b0;
        expect_next(4'd4, 1'b1, 1'b0); tick();
        idle_inputs();
        expect_next(4'd5, 1'b1, 1'b0); tick();
        expect_next(4'd6, 1'b1, 1'b0); tick();
        stop = 1'b1; load = 1'b1; load_val = 4'd9;
        expect_next(4'd6, 1'b0, 1'b0); tick();
        idle_inputs();
        start = 1'b1; stop = 1'b1;
        expect_next(4'd6, 1'b0, 1'b0); tick();

        step = "up_wrap";
        idle_inputs();
        load = 1'b1; load_val = 4'd14; start = 1'b1; dir = 1'b1; limit = 4'd2; cont = 1'b0;
        expect_next(4'd14, 1'b1, 1'b0); tick();
        idle_inputs();
        expect_next(4'd15, 1'b1, 1'b0); tick();
        expect_next(4'd0,  1'b1, 1'b0); tick();
        expect_next(4'd1,  1'b1, 1'b0); tick();
        expect_next(4'd2,  1'b1, 1'b0); tick();
        expect_next(4'd2,  1'b0, 1'b1); tick();
        expect_next(4'd2,  1'b0, 1'b0); tick();

        step = "midrun_reset";
        start = 1'b1; dir = 1'b1; limit = 4'd10; cont = 1'b0;
        expect_next(4'd2, 1'b1, 1'b0); tick();
        idle_inputs();
        expect_next(4'd3, 1'b1, 1'b0); tick();
        rst = 1'b1;
        expect_next(4'd0, 1'b0, 1'b0); tick();
        rst = 1'b0;
        expect_next(4'd0, 1'b0, 1'b0); tick();

        step = "limit_zero";
        start = 1'b1; dir = 1'b1; limit = 4'd0; cont = 1'b0;
        expect_next(4'd0, 1'b1, 1'b0); tick();
        idle_inputs();
        check("tc_limit0", {7'b0, tc}, 8'h01);
        expect_next(4'd0, 1'b0, 1'b1); tick();
        expect_next(4'd0, 1'b0, 1'b0); tick();

        check("sb_drained", 8'(sb.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
